serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Multi-cycle, bit-serial subtract unit that computes `A + ~B + carry` one bit per clock, LSB first, and produces ARM-style CNZV flags. It covers the SUB/SBC/RSB/RSC operations and is the inverse-operation companion to the combinational adder in the CPU datapath. The execute stage uses it when it can trade latency for area. A start/done handshake lets the control unit stall until the result is ready.

## Interface
- `WIDTH`, default `` `WordWidth `` (32): operand and result width; must be ≥ 2.

- `in_Clk`  input  1  clock; all state updates on the rising edge.
- `in_Rst_N`  input  1  reset, asynchronous, active-low.
- `in_Start`  input  1  request a new operation; sampled only in IDLE.
- `in_Rn`  input  WIDTH  first operand; captured on the accepting edge.
- `in_Op2`  input  WIDTH  second operand; captured on the accepting edge.
- `in_Carry`  input  1  carry-in (1 = no borrow); SUB/RSB drive 1, SBC/RSC drive the C flag.
- `in_Reverse`  input  1  0: A=Rn, B=Op2; 1: A=Op2, B=Rn (RSB/RSC).
- `out_Busy`  output  1  high while an operation is in progress.
- `out_Done`  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- `out_Y`  output  WIDTH  difference A − B − !carry, modulo 2^WIDTH.
- `out_CNZV`  output  4  {C, N, Z, V} of the last completed operation.

## Operation
- States: IDLE, RUN.
- **IDLE, in_Start=1:**
  - Latch A and B per in_Reverse.
  - Latch the carry register from in_Carry.
  - Clear the bit index.
  - Go to RUN.
- **RUN, each edge:**
  - sum = A[i] ^ ~B[i] ^ c.
  - c ← majority(A[i], ~B[i], c).
  - Shift sum into the internal result register.
  - Increment i.
  - The edge that processes bit WIDTH−1 goes to IDLE and loads the outputs.
- **Completion loads:**
  - out_Y ← full internal result.
  - C ← final carry out (1 = no borrow).
  - N ← Y[WIDTH−1].
  - Z ← (Y == 0).
  - V ← (A[msb] != B[msb]) && (Y[msb] != A[msb]).
  - out_Done ← 1 for one cycle.
- **Output holding:** out_Y and out_CNZV change only at completion. They hold their values through IDLE and through the next RUN.
- **in_Start while RUN:** ignored, with no effect on the operation in flight. Operand inputs are don't-care after the accepting edge.
- **Reset (in_Rst_N=0, any time, including mid-RUN):**
  - State → IDLE.
  - out_Busy=0, out_Done=0, out_Y=0, out_CNZV=4'b0000.
  - Internal registers cleared.
  - An aborted operation never produces out_Done.
- Arithmetic is unsigned modulo 2^WIDTH. The carry chain is exactly WIDTH bits, with no sign extension.

## Timing
- **Accepting edge E0:** in_Start=1 in IDLE. out_Busy goes high after E0.
- **Processing edges E1..E_WIDTH:** process bits 0..WIDTH−1.
- **After E_WIDTH:**
  - out_Busy=0 and out_Done=1.
  - out_Y and out_CNZV are valid.
  - Latency from the accepting edge to the Done cycle is WIDTH cycles.
- **After E_WIDTH+1:** out_Done=0, unless a new operation completes at that edge, which is impossible for WIDTH ≥ 2.
- **Back-to-back:** the Done cycle is an IDLE cycle. in_Start=1 in that cycle is accepted at E_WIDTH+1, giving one result every WIDTH+1 cycles.
- **Reset deassertion:** the first rising edge with in_Rst_N=1 may accept in_Start.

## Test plan
- **SUB:** Rn=5, Op2=3, Carry=1, Reverse=0 → out_Y=0x00000002, CNZV=4'b1000. out_Done high exactly 32 cycles after the accepting edge.
- **Negative result:** Rn=3, Op2=5, Carry=1 → out_Y=0xFFFFFFFE, CNZV=4'b0100.
- **Overflow:** Rn=0x80000000, Op2=1, Carry=1 → out_Y=0x7FFFFFFF, CNZV=4'b1001.
- **Zero and SBC:**
  - Rn=7, Op2=7, Carry=1 → out_Y=0, CNZV=4'b1010.
  - Same operands with Carry=0 → out_Y=0xFFFFFFFF, CNZV=4'b0100.
- **RSB:** Rn=10, Op2=3, Reverse=1, Carry=1 → out_Y=0xFFFFFFF9, CNZV=4'b0100.
- **Control:**
  - in_Start pulsed mid-RUN with different operands → ignored; the first result is unchanged.
  - Start asserted in the Done cycle → the second result arrives 33 cycles after the first.
  - in_Rst_N pulsed low at bit 10 → outputs all zero, no out_Done, and a fresh start then completes correctly.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A + ~B + carry unit, LSB first, one bit per
// clock. Produces the difference and ARM-style {C, N, Z, V} flags, with a
// start/done handshake so the control unit can stall on it.

`ifndef WordWidth
`define WordWidth 32
`endif

module serial_subtractor #(
  parameter int WIDTH = `WordWidth
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  input  logic             in_Start,
  input  logic [WIDTH-1:0] in_Rn,
  input  logic [WIDTH-1:0] in_Op2,
  input  logic             in_Carry,
  input  logic             in_Reverse,
  output logic             out_Busy,
  output logic             out_Done,
  output logic [WIDTH-1:0] out_Y,
  output logic [3:0]       out_CNZV
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Carry out of a full-adder cell.
  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               c_r;
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   res_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   y_r;
  logic [3:0]         cnzv_r;

  logic               a_bit_s;
  logic               b_inv_s;
  logic               sum_s;
  logic               carry_next_s;
  logic [WIDTH-1:0]   res_next_s;
  logic               last_s;

  // One full-adder step on the current bit, plus the shifted partial result.
  always_comb begin
    a_bit_s      = a_r[idx_r];
    b_inv_s      = ~b_r[idx_r];
    sum_s        = a_bit_s ^ b_inv_s ^ c_r;
    carry_next_s = majority(a_bit_s, b_inv_s, c_r);
    res_next_s   = {sum_s, res_r[WIDTH-1:1]};
    last_s       = (idx_r == LAST_IDX);
  end

  // Control FSM and datapath registers; outputs only move at completion.
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state_r <= ST_IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      y_r     <= {WIDTH{1'b0}};
      cnzv_r  <= 4'b0000;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_Start) begin
            a_r     <= in_Reverse ? in_Op2 : in_Rn;
            b_r     <= in_Reverse ? in_Rn  : in_Op2;
            c_r     <= in_Carry;
            idx_r   <= {IDX_W{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          c_r   <= carry_next_s;
          res_r <= res_next_s;
          idx_r <= idx_r + IDX_W'(1);
          if (last_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            y_r     <= res_next_s;
            // V: operands of different sign and result sign differs from A.
            cnzv_r  <= {carry_next_s,
                        res_next_s[WIDTH-1],
                        (res_next_s == {WIDTH{1'b0}}),
                        (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                        (res_next_s[WIDTH-1] != a_r[WIDTH-1])};
          end else begin
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out_Busy = busy_r;
  assign out_Done = done_r;
  assign out_Y    = y_r;
  assign out_CNZV = cnzv_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 32).

module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] rn;
  logic [31:0] op2;
  logic        carry;
  logic        reverse;
  logic        busy;
  logic        done;
  logic [31:0] y;
  logic [3:0]  cnzv;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(32)) dut (
    .in_Clk     (clk),
    .in_Rst_N   (rst_n),
    .in_Start   (start),
    .in_Rn      (rn),
    .in_Op2     (op2),
    .in_Carry   (carry),
    .in_Reverse (reverse),
    .out_Busy   (busy),
    .out_Done   (done),
    .out_Y      (y),
    .out_CNZV   (cnzv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operation for exactly one rising edge, then count negedges
  // until done is seen (cycles counted from the accepting edge).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic rev,
                        output int cycles, output logic timed_out);
    @(negedge clk);
    rn = a; op2 = b; carry = c; reverse = rev; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    timed_out = 1'b0;
    while (done !== 1'b1 && !timed_out) begin
      @(negedge clk);
      cycles++;
      if (cycles > 100) timed_out = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rn = 32'd0; op2 = 32'd0; carry = 1'b0; reverse = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 32'd0 || cnzv !== 4'b0000) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b y=%h cnzv=%b expected 0 0 00000000 0000", busy, done, y, cnzv);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sub();
    int cyc; logic to;
    run_op(32'd5, 32'd3, 1'b1, 1'b0, cyc, to);
    checks++;
    if (to || cyc != 32) begin
      failures++;
      $display("FAIL sub_latency: cycles=%0d timeout=%b expected 32", cyc, to);
    end
    checks++;
    if (y !== 32'h0000_0002 || cnzv !== 4'b1000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sub_result: y=%h cnzv=%b busy=%b expected 00000002 1000 0", y, cnzv, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || y !== 32'h0000_0002) begin
      failures++;
      $display("FAIL sub_done_pulse: done=%b y=%h expected 0 00000002", done, y);
    end
  endtask

  task automatic test_negative();
    int cyc; logic to;
    run_op(32'd3, 32'd5, 1'b1, 1'b0, cyc, to);
    checks++;
    if (to || y !== 32'hFFFF_FFFE || cnzv !== 4'b0100) begin
      failures++;
      $display("FAIL negative: y=%h cnzv=%b timeout=%b expected fffffffe 0100", y, cnzv, to);
    end
  endtask

  task automatic test_overflow();
    int cyc; logic to;
    run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, cyc, to);
    checks++;
    if (to || y !== 32'h7FFF_FFFF || cnzv !== 4'b1001) begin
      failures++;
      $display("FAIL overflow: y=%h cnzv=%b timeout=%b expected 7fffffff 1001", y, cnzv, to);
    end
  endtask

  task automatic test_zero_sbc();
    int cyc; logic to;
    run_op(32'd7, 32'd7, 1'b1, 1'b0, cyc, to);
    checks++;
    if (to || y !== 32'd0 || cnzv !== 4'b1010) begin
      failures++;
      $display("FAIL zero: y=%h cnzv=%b timeout=%b expected 00000000 1010", y, cnzv, to);
    end
    run_op(32'd7, 32'd7, 1'b0, 1'b0, cyc, to);
    checks++;
    if (to || y !== 32'hFFFF_FFFF || cnzv !== 4'b0100) begin
      failures++;
      $display("FAIL sbc: y=%h cnzv=%b timeout=%b expected ffffffff 0100", y, cnzv, to);
    end
  endtask

  task automatic test_rsb();
    int cyc; logic to;
    run_op(32'd10, 32'd3, 1'b1, 1'b1, cyc, to);
    checks++;
    if (to || y !== 32'hFFFF_FFF9 || cnzv !== 4'b0100) begin
      failures++;
      $display("FAIL rsb: y=%h cnzv=%b timeout=%b expected fffffff9 0100", y, cnzv, to);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    @(negedge clk);
    rn = 32'd100; op2 = 32'd1; carry = 1'b1; reverse = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc <= 100) begin
      if (cyc == 10) begin
        rn = 32'h1234_0000; op2 = 32'h0000_0042; carry = 1'b0; reverse = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 32 || y !== 32'd99 || cnzv !== 4'b1000) begin
      failures++;
      $display("FAIL start_ignored: cycles=%0d y=%h cnzv=%b expected 32 00000063 1000", cyc, y, cnzv);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; logic to;
    logic hold_ok;
    run_op(32'd20, 32'd5, 1'b1, 1'b0, cyc, to);
    // Now in the done cycle: request the next op right away.
    rn = 32'd1; op2 = 32'd2; carry = 1'b1; reverse = 1'b0; start = 1'b1;
    cyc = 0;
    hold_ok = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 5 && (y !== 32'd15 || cnzv !== 4'b1000 || busy !== 1'b1)) hold_ok = 1'b0;
    end while (done !== 1'b1 && cyc <= 100);
    checks++;
    if (!hold_ok) begin
      failures++;
      $display("FAIL b2b_hold: outputs not holding 0000000f/1000 with busy during second run");
    end
    checks++;
    if (cyc != 33) begin
      failures++;
      $display("FAIL b2b_spacing: cycles=%0d expected 33", cyc);
    end
    checks++;
    if (y !== 32'hFFFF_FFFF || cnzv !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_result: y=%h cnzv=%b expected ffffffff 0100", y, cnzv);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc; logic to;
    logic saw_done;
    @(negedge clk);
    rn = 32'd9; op2 = 32'd4; carry = 1'b1; reverse = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 32'd0 || cnzv !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_run: busy=%b done=%b y=%h cnzv=%b expected 0 0 00000000 0000", busy, done, y, cnzv);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_abort: aborted op produced busy/done got 1 expected 0");
    end
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, cyc, to);
    checks++;
    if (to || cyc != 32 || y !== 32'h0123_4567 || cnzv !== 4'b1000) begin
      failures++;
      $display("FAIL reset_restart: y=%h cnzv=%b cycles=%0d expected 01234567 1000 32", y, cnzv, cyc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_sub();
    test_negative();
    test_overflow();
    test_zero_sbc();
    test_rsb();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
